// File: rtl/udp_depacketizer.sv
`default_nettype none
// ============================================================================
//  Module   : udp_depacketizer
//  Purpose  : Parses byte-wise Ethernet/IPv4/UDP frames, filters on MAC/IP/port
//             and pushes the carried 32-bit IQ samples into the TX sample FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module udp_depacketizer #(
    parameter logic [47:0] LOCAL_MAC  = 48'h021234567890,
    parameter logic [31:0] LOCAL_IP   = {8'd10, 8'd0, 8'd0, 8'd2},
    parameter logic [15:0] LOCAL_PORT = 16'd32179
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_dval,
    input  logic        rx_sop,
    input  logic        rx_eop,
    input  logic        rx_err,
    output logic        wr_en,
    output logic [31:0] wr_data,
    input  logic        wr_full,
    output logic        frame_ok,
    output logic        frame_drop,
    output logic        seq_gap,
    output logic        overflow,
    output logic [63:0] last_seq,
    output logic [15:0] drop_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_PAYLOAD = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    localparam logic [5:0]  c_last_hdr_byte = 6'd49;
    localparam logic [15:0] c_seq_hdr_len   = 16'd16;

    state_t      r_state;
    logic [5:0]  r_byte_idx;
    logic        r_mac_local;
    logic        r_mac_bcast;
    logic [7:0]  r_len_hi;
    logic [15:0] r_udp_len;
    logic [63:0] r_seq_tmp;
    logic [63:0] r_expected;
    logic        r_seq_valid;
    logic [15:0] r_payload_left;
    logic [1:0]  r_k;
    logic [15:0] r_i;
    logic [7:0]  r_q_lo;

    logic [5:0]  w_idx;
    logic        w_sop;
    logic        w_eop;
    logic [7:0]  w_mac_byte;
    logic        w_mac_local;
    logic        w_mac_bcast;
    logic        w_hdr_bad;
    logic [15:0] w_udp_len;
    logic        w_pay_beat;
    logic        w_k3;
    logic [15:0] w_left_next;
    logic        w_clean;
    logic        w_drop;

    assign w_sop     = rx_dval & rx_sop;
    assign w_eop     = rx_dval & rx_eop;
    assign w_idx     = rx_sop ? 6'd0 : r_byte_idx;
    assign w_udp_len = {r_len_hi, rx_data};

    always_comb begin
        w_mac_byte = 8'h00;
        case (w_idx)
            6'd0:    w_mac_byte = LOCAL_MAC[47:40];
            6'd1:    w_mac_byte = LOCAL_MAC[39:32];
            6'd2:    w_mac_byte = LOCAL_MAC[31:24];
            6'd3:    w_mac_byte = LOCAL_MAC[23:16];
            6'd4:    w_mac_byte = LOCAL_MAC[15:8];
            6'd5:    w_mac_byte = LOCAL_MAC[7:0];
            default: w_mac_byte = 8'h00;
        endcase
    end

    // Running match flags; a start-of-frame beat restarts both comparisons.
    assign w_mac_local = (rx_sop | r_mac_local) & (rx_data == w_mac_byte);
    assign w_mac_bcast = (rx_sop | r_mac_bcast) & (rx_data == 8'hFF);

    always_comb begin
        w_hdr_bad = 1'b0;
        case (w_idx)
            6'd5:    w_hdr_bad = ~(w_mac_local | w_mac_bcast);
            6'd12:   w_hdr_bad = (rx_data != 8'h08);
            6'd13:   w_hdr_bad = (rx_data != 8'h00);
            6'd14:   w_hdr_bad = (rx_data != 8'h45);
            6'd23:   w_hdr_bad = (rx_data != 8'h11);
            6'd30:   w_hdr_bad = (rx_data != LOCAL_IP[31:24]);
            6'd31:   w_hdr_bad = (rx_data != LOCAL_IP[23:16]);
            6'd32:   w_hdr_bad = (rx_data != LOCAL_IP[15:8]);
            6'd33:   w_hdr_bad = (rx_data != LOCAL_IP[7:0]);
            6'd36:   w_hdr_bad = (rx_data != LOCAL_PORT[15:8]);
            6'd37:   w_hdr_bad = (rx_data != LOCAL_PORT[7:0]);
            6'd39:   w_hdr_bad = (w_udp_len < c_seq_hdr_len) | (w_udp_len[1:0] != 2'b00);
            default: w_hdr_bad = 1'b0;
        endcase
    end

    // Once payload_left reaches zero the remaining bytes are padding.
    assign w_pay_beat  = rx_dval & ~rx_sop & (r_state == S_PAYLOAD) & (r_payload_left != 16'd0);
    assign w_k3        = w_pay_beat & (r_k == 2'd3);
    assign w_left_next = w_pay_beat ? (r_payload_left - 16'd1) : r_payload_left;
    assign w_clean     = w_eop & ~rx_sop & ~rx_err & (r_state == S_PAYLOAD) & (w_left_next == 16'd0);
    assign w_drop      = (w_sop & (r_state != S_IDLE)) |
                         (w_eop & ~w_clean & (rx_sop | (r_state != S_IDLE)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_byte_idx     <= 6'd0;
            r_mac_local    <= 1'b0;
            r_mac_bcast    <= 1'b0;
            r_len_hi       <= 8'h00;
            r_udp_len      <= 16'd0;
            r_seq_tmp      <= 64'd0;
            r_expected     <= 64'd0;
            r_seq_valid    <= 1'b0;
            r_payload_left <= 16'd0;
            r_k            <= 2'd0;
            r_i            <= 16'd0;
            r_q_lo         <= 8'h00;
            wr_en          <= 1'b0;
            wr_data        <= 32'd0;
            frame_ok       <= 1'b0;
            frame_drop     <= 1'b0;
            seq_gap        <= 1'b0;
            overflow       <= 1'b0;
            last_seq       <= 64'd0;
            drop_count     <= 16'd0;
        end else begin
            wr_en      <= 1'b0;
            frame_ok   <= 1'b0;
            seq_gap    <= 1'b0;
            overflow   <= 1'b0;
            frame_drop <= w_drop;

            if (w_drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end

            if (w_k3) begin
                if (!wr_full) begin
                    wr_en   <= 1'b1;
                    wr_data <= {r_i, rx_data, r_q_lo};
                end else begin
                    overflow <= 1'b1;
                end
            end

            if (w_clean) begin
                frame_ok    <= 1'b1;
                last_seq    <= r_seq_tmp;
                seq_gap     <= r_seq_valid && (r_seq_tmp != r_expected);
                r_expected  <= r_seq_tmp + 64'd1;
                r_seq_valid <= 1'b1;
            end

            if (rx_dval) begin
                if (rx_sop) begin
                    r_mac_local <= w_mac_local;
                    r_mac_bcast <= w_mac_bcast;
                    r_byte_idx  <= 6'd1;
                    r_state     <= rx_eop ? S_IDLE : S_HEADER;
                end else begin
                    case (r_state)
                        S_HEADER: begin
                            r_mac_local <= w_mac_local;
                            r_mac_bcast <= w_mac_bcast;
                            r_byte_idx  <= r_byte_idx + 6'd1;
                            if (w_idx == 6'd38) r_len_hi  <= rx_data;
                            if (w_idx == 6'd39) r_udp_len <= w_udp_len;
                            // Little-endian sequence: byte 42 ends up in bits 7:0.
                            if (w_idx >= 6'd42) r_seq_tmp <= {rx_data, r_seq_tmp[63:8]};
                            if (rx_eop) begin
                                r_state <= S_IDLE;
                            end else if (w_hdr_bad) begin
                                r_state <= S_DISCARD;
                            end else if (r_byte_idx == c_last_hdr_byte) begin
                                r_state        <= S_PAYLOAD;
                                r_payload_left <= r_udp_len - c_seq_hdr_len;
                                r_k            <= 2'd0;
                            end
                        end
                        S_PAYLOAD: begin
                            if (w_pay_beat) begin
                                r_payload_left <= w_left_next;
                                r_k            <= r_k + 2'd1;
                                case (r_k)
                                    2'd0:    r_i[7:0]  <= rx_data;
                                    2'd1:    r_i[15:8] <= rx_data;
                                    2'd2:    r_q_lo    <= rx_data;
                                    default: r_q_lo    <= r_q_lo;
                                endcase
                            end
                            if (rx_eop) r_state <= S_IDLE;
                        end
                        S_DISCARD: begin
                            if (rx_eop) r_state <= S_IDLE;
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire
